// File: rtl/tetris_board_engine.sv
// tetris_board_engine: board memory, active piece, collision, lock, line clear, scoring and renderer row port
module tetris_board_engine #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int X_W = 5,
  parameter int Y_W = 5,
  parameter int SCORE_W = 16,
  parameter int SPAWN_X = 3
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                start_final,
  input  logic                left_final,
  input  logic                right_final,
  input  logic                rot_final,
  input  logic                drop_final,
  input  logic                tick_gravity,
  input  logic [2:0]          shape_next,
  output logic [3:0]          state,
  output logic [X_W-1:0]      piece_x,
  output logic [Y_W-1:0]      piece_y,
  output logic [1:0]          rot,
  output logic [2:0]          shape_id,
  output logic [SCORE_W-1:0]  score,
  output logic [2:0]          lines_last,
  output logic                move_accept,
  output logic                collide,
  output logic                lock_phase,
  output logic                game_over,
  input  logic [Y_W-1:0]      row_sel,
  output logic [BOARD_W-1:0]  row_bits
);
  localparam int RW = $clog2(BOARD_H);
  localparam int CW = $clog2(BOARD_W);
  typedef enum logic [3:0] {IDLE, SPAWN, FALL, LOCK, CLEAR, OVER} st_t;
  st_t st, st_n;
  logic [BOARD_W-1:0] board [BOARD_H];
  logic [BOARD_W-1:0] prow [BOARD_H];
  logic drop, hit, try_mv, t_down, t_rot, t_left, t_right, full;
  logic [RW-1:0] scan;
  logic [2:0] cnt, c_shape;
  logic [1:0] c_rot;
  logic [15:0] c_mask, p_mask;
  logic [3:0] pts;
  logic [SCORE_W:0] sum;
  int cx, cy, rr, cc, pr, pc;
  function automatic logic [15:0] mask_of(input logic [2:0] s, input logic [1:0] r);
    logic [63:0] m;
    m = s == 3'd0 ? 64'h2222_0F00_4444_00F0 :
        s == 3'd2 ? 64'h0232_0270_0262_0072 :
        s == 3'd3 ? 64'h0231_0360_0462_0036 :
        s == 3'd4 ? 64'h0132_0630_0264_0063 :
        s == 3'd5 ? 64'h0322_0470_0226_0071 :
        s == 3'd6 ? 64'h0223_0170_0622_0074 : 64'h0066_0066_0066_0066;
    return m[{r, 4'b0} +: 16];
  endfunction
  always_comb begin
    t_down = drop | (~drop_final & ~rot_final & ~left_final & ~right_final & tick_gravity);
    t_rot = ~drop & ~drop_final & rot_final;
    t_left = ~drop & ~drop_final & ~rot_final & left_final;
    t_right = ~drop & ~drop_final & ~rot_final & ~left_final & right_final;
    try_mv = st == FALL && (t_down | t_rot | t_left | t_right);
    c_shape = st == SPAWN ? shape_next : shape_id;
    c_rot = st == SPAWN ? 2'd0 : rot + 2'(t_rot);
    cx = st == SPAWN ? SPAWN_X : int'($signed(piece_x)) - int'(t_left) + int'(t_right);
    cy = st == SPAWN ? 0 : int'(piece_y) + int'(t_down);
    c_mask = mask_of(c_shape, c_rot);
    hit = 1'b0;
    rr = 0;
    cc = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        rr = cy + r;
        cc = cx + c;
        if (c_mask[r*4+c])
          hit = hit | ((cc < 0 || cc >= BOARD_W || rr >= BOARD_H) ? 1'b1 : board[rr[RW-1:0]][cc[CW-1:0]]);
      end
  end
  always_comb begin
    p_mask = mask_of(shape_id, rot);
    pr = 0;
    pc = 0;
    for (int i = 0; i < BOARD_H; i++) prow[i] = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        pr = int'(piece_y) + r;
        pc = int'($signed(piece_x)) + c;
        if (p_mask[r*4+c] && pr < BOARD_H && pc >= 0 && pc < BOARD_W) prow[pr[RW-1:0]][pc[CW-1:0]] = 1'b1;
      end
  end
  always_comb begin
    full = &board[scan];
    pts = cnt == 3'd1 ? 4'd1 : cnt == 3'd2 ? 4'd3 : cnt == 3'd3 ? 4'd5 : cnt == 3'd4 ? 4'd8 : 4'd0;
    sum = {1'b0, score} + (SCORE_W+1)'(pts);
    st_n = st;
    case (st)
      IDLE:  st_n = start_final ? SPAWN : IDLE;
      SPAWN: st_n = hit ? OVER : FALL;
      FALL:  st_n = try_mv && hit && t_down ? LOCK : FALL;
      LOCK:  st_n = CLEAR;
      CLEAR: st_n = !full && scan == '0 ? SPAWN : CLEAR;
      OVER:  st_n = start_final ? SPAWN : OVER;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) st <= IDLE;
    else st <= st_n;
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      piece_x <= X_W'(SPAWN_X);
      piece_y <= '0;
      rot <= '0;
      shape_id <= '0;
      score <= '0;
      lines_last <= '0;
      move_accept <= 1'b0;
      collide <= 1'b0;
      drop <= 1'b0;
      scan <= '0;
      cnt <= '0;
      for (int i = 0; i < BOARD_H; i++) board[i] <= '0;
    end else begin
      move_accept <= try_mv & ~hit;
      collide <= try_mv & hit;
      case (st)
        SPAWN: begin
          shape_id <= shape_next;
          rot <= '0;
          piece_x <= X_W'(SPAWN_X);
          piece_y <= '0;
        end
        FALL: begin
          if (drop_final) drop <= 1'b1;
          if (try_mv && !hit) begin
            piece_x <= X_W'(cx);
            piece_y <= Y_W'(cy);
            rot <= c_rot;
          end
          if (try_mv && hit && t_down) drop <= 1'b0;
        end
        LOCK: begin
          for (int i = 0; i < BOARD_H; i++) board[i] <= board[i] | prow[i];
          cnt <= '0;
          scan <= RW'(BOARD_H-1);
        end
        CLEAR:
          if (full) begin
            board[0] <= '0;
            for (int i = 1; i < BOARD_H; i++) if (i <= int'(scan)) board[i] <= board[i-1];
            cnt <= cnt + 3'd1;
          end else if (scan != '0) scan <= scan - 1'b1;
          else begin
            score <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
            lines_last <= cnt;
          end
        OVER:
          if (start_final) begin
            for (int i = 0; i < BOARD_H; i++) board[i] <= '0;
            score <= '0;
            lines_last <= '0;
          end
        default: ;
      endcase
    end
  assign state = st;
  assign lock_phase = st == LOCK || st == CLEAR;
  assign game_over = st == OVER;
  assign row_bits = int'(row_sel) < BOARD_H ? board[row_sel[RW-1:0]] | (st == FALL ? prow[row_sel[RW-1:0]] : '0) : '0;
endmodule

// File: tb/tb_tetris_board_engine.sv
// tb_tetris_board_engine: directed scenario bench for tetris_board_engine
module tb_tetris_board_engine;
  logic clk = 0, resetn = 0, start_final = 0, left_final = 0, right_final = 0;
  logic rot_final = 0, drop_final = 0, tick_gravity = 0;
  logic [2:0] shape_next = 0;
  logic [3:0] state;
  logic signed [4:0] piece_x;
  logic [4:0] piece_y;
  logic [4:0] row_sel = 0;
  logic [1:0] rot;
  logic [2:0] shape_id, lines_last;
  logic [15:0] score;
  logic move_accept, collide, lock_phase, game_over;
  logic [9:0] row_bits, rv;
  int vecs = 0, errs = 0;
  bit ok;
  always #5 clk = ~clk;
  tetris_board_engine dut (
    .CLOCK_50(clk), .resetn(resetn), .start_final(start_final), .left_final(left_final),
    .right_final(right_final), .rot_final(rot_final), .drop_final(drop_final),
    .tick_gravity(tick_gravity), .shape_next(shape_next), .state(state), .piece_x(piece_x),
    .piece_y(piece_y), .rot(rot), .shape_id(shape_id), .score(score), .lines_last(lines_last),
    .move_accept(move_accept), .collide(collide), .lock_phase(lock_phase), .game_over(game_over),
    .row_sel(row_sel), .row_bits(row_bits)
  );
  task automatic start_game(input logic [2:0] s);
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    shape_next = s;
    start_final = 1;
    @(negedge clk);
    start_final = 0;
    @(negedge clk);
  endtask
  task automatic pulse(input logic [3:0] m);
    {drop_final, rot_final, left_final, right_final} = m;
    @(negedge clk);
    {drop_final, rot_final, left_final, right_final} = 4'b0;
  endtask
  task automatic get_row(input int r, output logic [9:0] v);
    row_sel = 5'(r);
    #1;
    v = row_bits;
  endtask
  task automatic wait_state(input logic [3:0] s, output bit found);
    found = 0;
    for (int i = 0; i < 100 && !found; i++)
      if (state === s) found = 1;
      else @(negedge clk);
  endtask
  task automatic test_reset;
    resetn = 0;
    @(negedge clk);
    vecs++; if (state !== 4'd0) begin errs++; $display("FAIL reset_state: got %0d want 0", state); end
    vecs++; if (piece_x !== 5'sd3 || piece_y !== 5'd0) begin errs++; $display("FAIL reset_pos: got x=%0d y=%0d want x=3 y=0", piece_x, piece_y); end
    vecs++; if (rot !== 2'd0 || shape_id !== 3'd0) begin errs++; $display("FAIL reset_piece: got rot=%0d shape=%0d want 0 0", rot, shape_id); end
    vecs++; if (score !== 16'd0 || lines_last !== 3'd0) begin errs++; $display("FAIL reset_score: got score=%0d lines=%0d want 0 0", score, lines_last); end
    vecs++; if ({move_accept, collide, lock_phase, game_over} !== 4'b0) begin errs++; $display("FAIL reset_flags: got %b want 0000", {move_accept, collide, lock_phase, game_over}); end
  endtask
  task automatic test_spawn;
    resetn = 1;
    shape_next = 3'd1;
    start_final = 1;
    @(negedge clk);
    start_final = 0;
    vecs++; if (state !== 4'd1) begin errs++; $display("FAIL spawn_state: got %0d want 1", state); end
    @(negedge clk);
    vecs++; if (state !== 4'd2) begin errs++; $display("FAIL spawn_fall: got %0d want 2", state); end
    vecs++; if (piece_x !== 5'sd3 || piece_y !== 5'd0 || shape_id !== 3'd1) begin errs++; $display("FAIL spawn_pos: got x=%0d y=%0d shape=%0d want 3 0 1", piece_x, piece_y, shape_id); end
    get_row(0, rv);
    vecs++; if (rv !== 10'h030) begin errs++; $display("FAIL spawn_row0: got %h want 030", rv); end
    get_row(1, rv);
    vecs++; if (rv !== 10'h030) begin errs++; $display("FAIL spawn_row1: got %h want 030", rv); end
    get_row(2, rv);
    vecs++; if (rv !== 10'h000) begin errs++; $display("FAIL spawn_row2: got %h want 000", rv); end
  endtask
  task automatic test_left_wall;
    for (int i = 1; i <= 5; i++) begin
      pulse(4'b0010);
      if (i < 5) begin
        vecs++; if (move_accept !== 1'b1 || collide !== 1'b0 || piece_x !== 5'(3 - i)) begin errs++; $display("FAIL left_step%0d: got acc=%b col=%b x=%0d want 1 0 %0d", i, move_accept, collide, piece_x, 3 - i); end
      end else begin
        vecs++; if (collide !== 1'b1 || move_accept !== 1'b0 || piece_x !== -5'sd1) begin errs++; $display("FAIL left_wall: got acc=%b col=%b x=%0d want 0 1 -1", move_accept, collide, piece_x); end
      end
      @(negedge clk);
      if (i == 1) begin
        vecs++; if (move_accept !== 1'b0) begin errs++; $display("FAIL accept_pulse: got %b want 0", move_accept); end
      end
    end
  endtask
  task automatic test_gravity_lock;
    int n;
    start_game(3'd0);
    for (int i = 1; i <= 19; i++) begin
      tick_gravity = 1;
      @(negedge clk);
      tick_gravity = 0;
      if (i < 19) begin
        vecs++; if (move_accept !== 1'b1 || piece_y !== 5'(i)) begin errs++; $display("FAIL grav_step%0d: got acc=%b y=%0d want 1 %0d", i, move_accept, piece_y, i); end
      end
    end
    vecs++; if (collide !== 1'b1 || move_accept !== 1'b0 || piece_y !== 5'd18) begin errs++; $display("FAIL grav_block: got acc=%b col=%b y=%0d want 0 1 18", move_accept, collide, piece_y); end
    vecs++; if (state !== 4'd3 || lock_phase !== 1'b1) begin errs++; $display("FAIL grav_lock: got state=%0d lp=%b want 3 1", state, lock_phase); end
    n = 0;
    @(negedge clk);
    while (state === 4'd4 && n < 40) begin
      n++;
      @(negedge clk);
    end
    vecs++; if (n != 20 || state !== 4'd1) begin errs++; $display("FAIL clear_cycles: got %0d cycles then state %0d want 20 then 1", n, state); end
    @(negedge clk);
    vecs++; if (state !== 4'd2) begin errs++; $display("FAIL respawn: got %0d want 2", state); end
    get_row(19, rv);
    vecs++; if (rv !== 10'h078) begin errs++; $display("FAIL grav_row19: got %h want 078", rv); end
    vecs++; if (lines_last !== 3'd0 || score !== 16'd0) begin errs++; $display("FAIL grav_score: got lines=%0d score=%0d want 0 0", lines_last, score); end
  endtask
  task automatic test_rotate_priority;
    start_game(3'd0);
    pulse(4'b0111);
    vecs++; if (rot !== 2'd1 || piece_x !== 5'sd3 || move_accept !== 1'b1) begin errs++; $display("FAIL rot_prio: got rot=%0d x=%0d acc=%b want 1 3 1", rot, piece_x, move_accept); end
    get_row(3, rv);
    vecs++; if (rv !== 10'h020) begin errs++; $display("FAIL rot_row3: got %h want 020", rv); end
    for (int i = 0; i < 5; i++) pulse(4'b0001);
    vecs++; if (collide !== 1'b1 || piece_x !== 5'sd7) begin errs++; $display("FAIL right_wall: got col=%b x=%0d want 1 7", collide, piece_x); end
    get_row(0, rv);
    vecs++; if (rv !== 10'h200) begin errs++; $display("FAIL right_row0: got %h want 200", rv); end
  endtask
  task automatic test_line_clear;
    start_game(3'd0);
    for (int i = 0; i < 3; i++) pulse(4'b0010);
    pulse(4'b1000);
    wait_state(4'd3, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL lc_lock1: timeout, state %0d want 3", state); end
    wait_state(4'd2, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL lc_spawn1: timeout, state %0d want 2", state); end
    pulse(4'b0001);
    pulse(4'b1000);
    shape_next = 3'd1;
    wait_state(4'd3, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL lc_lock2: timeout, state %0d want 3", state); end
    wait_state(4'd2, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL lc_spawn2: timeout, state %0d want 2", state); end
    for (int i = 0; i < 4; i++) pulse(4'b0001);
    pulse(4'b1000);
    wait_state(4'd3, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL lc_lock3: timeout, state %0d want 3", state); end
    wait_state(4'd2, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL lc_spawn3: timeout, state %0d want 2", state); end
    vecs++; if (lines_last !== 3'd1 || score !== 16'd1) begin errs++; $display("FAIL lc_score: got lines=%0d score=%0d want 1 1", lines_last, score); end
    get_row(19, rv);
    vecs++; if (rv !== 10'h300) begin errs++; $display("FAIL lc_row19: got %h want 300", rv); end
    get_row(18, rv);
    vecs++; if (rv !== 10'h000) begin errs++; $display("FAIL lc_row18: got %h want 000", rv); end
  endtask
  task automatic test_async_reset;
    pulse(4'b1000);
    wait_state(4'd4, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL ar_clear: timeout, state %0d want 4", state); end
    #2 resetn = 0;
    #1;
    vecs++; if (state !== 4'd0 || lock_phase !== 1'b0) begin errs++; $display("FAIL ar_state: got state=%0d lp=%b want 0 0", state, lock_phase); end
    vecs++; if (score !== 16'd0 || lines_last !== 3'd0) begin errs++; $display("FAIL ar_score: got score=%0d lines=%0d want 0 0", score, lines_last); end
    vecs++; if (piece_x !== 5'sd3 || piece_y !== 5'd0 || shape_id !== 3'd0) begin errs++; $display("FAIL ar_piece: got x=%0d y=%0d shape=%0d want 3 0 0", piece_x, piece_y, shape_id); end
    get_row(19, rv);
    vecs++; if (rv !== 10'h000) begin errs++; $display("FAIL ar_row19: got %h want 000", rv); end
    @(negedge clk);
    resetn = 1;
  endtask
  task automatic test_hard_drop;
    start_game(3'd1);
    pulse(4'b1010);
    vecs++; if (piece_x !== 5'sd3 || piece_y !== 5'd0 || move_accept !== 1'b0 || collide !== 1'b0) begin errs++; $display("FAIL hd_arm: got x=%0d y=%0d acc=%b col=%b want 3 0 0 0", piece_x, piece_y, move_accept, collide); end
    for (int i = 1; i <= 18; i++) begin
      left_final = (i == 3);
      tick_gravity = (i == 5);
      @(negedge clk);
      left_final = 0;
      tick_gravity = 0;
      vecs++; if (piece_y !== 5'(i) || piece_x !== 5'sd3 || move_accept !== 1'b1) begin errs++; $display("FAIL hd_step%0d: got y=%0d x=%0d acc=%b want %0d 3 1", i, piece_y, piece_x, move_accept, i); end
    end
    @(negedge clk);
    vecs++; if (collide !== 1'b1 || state !== 4'd3 || piece_y !== 5'd18) begin errs++; $display("FAIL hd_lock: got col=%b state=%0d y=%0d want 1 3 18", collide, state, piece_y); end
    wait_state(4'd2, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL hd_spawn: timeout, state %0d want 2", state); end
    get_row(19, rv);
    vecs++; if (rv !== 10'h030) begin errs++; $display("FAIL hd_row19: got %h want 030", rv); end
    get_row(17, rv);
    vecs++; if (rv !== 10'h000) begin errs++; $display("FAIL hd_row17: got %h want 000", rv); end
  endtask
  task automatic test_game_over;
    start_game(3'd1);
    for (int k = 0; k < 10; k++) begin
      wait_state(4'd2, ok);
      vecs++; if (!ok) begin errs++; $display("FAIL go_spawn%0d: timeout, state %0d want 2", k, state); end
      pulse(4'b1000);
      wait_state(4'd3, ok);
      vecs++; if (!ok) begin errs++; $display("FAIL go_lock%0d: timeout, state %0d want 3", k, state); end
    end
    wait_state(4'd5, ok);
    vecs++; if (!ok || game_over !== 1'b1) begin errs++; $display("FAIL go_over: got state=%0d go=%b want 5 1", state, game_over); end
    get_row(0, rv);
    vecs++; if (rv !== 10'h030) begin errs++; $display("FAIL go_row0: got %h want 030", rv); end
    start_final = 1;
    @(negedge clk);
    start_final = 0;
    vecs++; if (state !== 4'd1 || game_over !== 1'b0 || score !== 16'd0) begin errs++; $display("FAIL go_restart: got state=%0d go=%b score=%0d want 1 0 0", state, game_over, score); end
    get_row(19, rv);
    vecs++; if (rv !== 10'h000) begin errs++; $display("FAIL go_cleared: got %h want 000", rv); end
    @(negedge clk);
    vecs++; if (state !== 4'd2) begin errs++; $display("FAIL go_fall: got %0d want 2", state); end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_spawn;
    test_left_wall;
    test_gravity_lock;
    test_rotate_priority;
    test_line_clear;
    test_async_reset;
    test_hard_drop;
    test_game_over;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
